// File: rtl/maze_pkg.sv
// Shared types and constants for the maze player controller.
// Cells are addressed as x + 16*y in the 256-bit maze bitmap.
package maze_pkg;

  localparam int GRID_W     = 16;
  localparam int GRID_H     = 16;
  localparam int CELL_COUNT = GRID_W * GRID_H;

  localparam logic CELL_PATH = 1'b1;
  localparam logic CELL_WALL = 1'b0;

  typedef enum logic [1:0] {WAIT_MAZE, PLAY, WON} state_e;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  // Concatenation equals x + 16*y because the grid is exactly 16 wide.
  function automatic logic [7:0] cell_index(input logic [3:0] x, input logic [3:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/maze_btn_repeat.sv
// Turns four button levels into move-attempt pulses: one on a new direction,
// then one every REPEAT_CYCLES clocks while the same single button is held.
module maze_btn_repeat
  import maze_pkg::*;
#(
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       attempt,
  output logic [1:0] dir
);

  localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             req_valid;
  dir_e             req_dir;
  logic             held_q, held_d;
  dir_e             last_dir_q, last_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    req_valid  = 1'b0;
    req_dir    = DIR_UP;
    attempt    = 1'b0;
    held_d     = held_q;
    last_dir_d = last_dir_q;
    cnt_d      = cnt_q;

    case ({btn_up, btn_down, btn_left, btn_right})
      4'b1000: begin req_valid = 1'b1; req_dir = DIR_UP;    end
      4'b0100: begin req_valid = 1'b1; req_dir = DIR_DOWN;  end
      4'b0010: begin req_valid = 1'b1; req_dir = DIR_LEFT;  end
      4'b0001: begin req_valid = 1'b1; req_dir = DIR_RIGHT; end
      default: req_valid = 1'b0;
    endcase

    // Disabled or ambiguous input forgets the held direction, so the next
    // valid press counts as a fresh one.
    if (!enable || !req_valid) begin
      held_d = 1'b0;
      cnt_d  = '0;
    end else if (!held_q || req_dir != last_dir_q) begin
      attempt    = 1'b1;
      held_d     = 1'b1;
      last_dir_d = req_dir;
      cnt_d      = '0;
    end else if (cnt_q == CNT_LAST) begin
      attempt = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign dir = req_dir;

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q     <= 1'b0;
      last_dir_q <= DIR_UP;
      cnt_q      <= '0;
    end else begin
      held_q     <= held_d;
      last_dir_q <= last_dir_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/maze_player_ctrl.sv
// Player controller: snapshots the carved maze, walks a token through path
// cells under button control, counts moves and detects arrival at the goal.
module maze_player_ctrl
  import maze_pkg::*;
#(
  parameter int START_X       = 1,
  parameter int START_Y       = 1,
  parameter int GOAL_X        = 14,
  parameter int GOAL_Y        = 14,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  maze_finish,
  input  logic [CELL_COUNT-1:0] maze_data,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  output logic [3:0]            player_x,
  output logic [3:0]            player_y,
  output logic [9:0]            move_count,
  output logic                  bump,
  output logic                  active,
  output logic                  won
);

  localparam logic [3:0] START_X4 = 4'(START_X);
  localparam logic [3:0] START_Y4 = 4'(START_Y);
  localparam logic [3:0] GOAL_X4  = 4'(GOAL_X);
  localparam logic [3:0] GOAL_Y4  = 4'(GOAL_Y);
  localparam logic [3:0] MAX_X    = 4'(GRID_W - 1);
  localparam logic [3:0] MAX_Y    = 4'(GRID_H - 1);
  localparam logic [9:0] COUNT_MAX = '1;

  state_e                state_q, state_d;
  logic [CELL_COUNT-1:0] snapshot_q, snapshot_d;
  logic [3:0]            player_x_q, player_x_d;
  logic [3:0]            player_y_q, player_y_d;
  logic [9:0]            move_count_q, move_count_d;
  logic                  bump_q, bump_d;
  logic                  active_q, active_d;
  logic                  won_q, won_d;

  logic       attempt;
  logic [1:0] attempt_dir;
  logic [3:0] tgt_x, tgt_y;
  logic       in_bounds;
  logic       legal;

  maze_btn_repeat #(
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_btn_repeat (
    .clk      (clk),
    .reset    (reset),
    .enable   (state_q == PLAY),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .attempt  (attempt),
    .dir      (attempt_dir)
  );

  // Edge checks come before the subtraction/addition so that a wrapped
  // target coordinate is never considered legal.
  always_comb begin
    tgt_x     = player_x_q;
    tgt_y     = player_y_q;
    in_bounds = 1'b0;
    case (dir_e'(attempt_dir))
      DIR_UP:    begin in_bounds = (player_y_q != 4'd0);  tgt_y = player_y_q - 4'd1; end
      DIR_DOWN:  begin in_bounds = (player_y_q != MAX_Y); tgt_y = player_y_q + 4'd1; end
      DIR_LEFT:  begin in_bounds = (player_x_q != 4'd0);  tgt_x = player_x_q - 4'd1; end
      DIR_RIGHT: begin in_bounds = (player_x_q != MAX_X); tgt_x = player_x_q + 4'd1; end
      default:   in_bounds = 1'b0;
    endcase
    legal = in_bounds && (snapshot_q[cell_index(tgt_x, tgt_y)] == CELL_PATH);
  end

  always_comb begin
    state_d      = state_q;
    snapshot_d   = snapshot_q;
    player_x_d   = player_x_q;
    player_y_d   = player_y_q;
    move_count_d = move_count_q;
    bump_d       = 1'b0;
    active_d     = active_q;
    won_d        = won_q;

    case (state_q)
      WAIT_MAZE: begin
        player_x_d = START_X4;
        player_y_d = START_Y4;
        if (maze_finish) begin
          snapshot_d   = maze_data;
          move_count_d = '0;
          active_d     = 1'b1;
          state_d      = PLAY;
        end
      end
      PLAY: begin
        // Losing the maze wins over any simultaneous move attempt.
        if (!maze_finish) begin
          state_d    = WAIT_MAZE;
          active_d   = 1'b0;
          player_x_d = START_X4;
          player_y_d = START_Y4;
        end else if (attempt) begin
          if (legal) begin
            player_x_d = tgt_x;
            player_y_d = tgt_y;
            if (move_count_q != COUNT_MAX) begin
              move_count_d = move_count_q + 10'd1;
            end
            if (tgt_x == GOAL_X4 && tgt_y == GOAL_Y4) begin
              state_d  = WON;
              active_d = 1'b0;
              won_d    = 1'b1;
            end
          end else begin
            bump_d = 1'b1;
          end
        end
      end
      WON: begin
        if (!maze_finish) begin
          state_d    = WAIT_MAZE;
          won_d      = 1'b0;
          player_x_d = START_X4;
          player_y_d = START_Y4;
        end
      end
      default: begin
        state_d  = WAIT_MAZE;
        active_d = 1'b0;
        won_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_MAZE;
      snapshot_q   <= {CELL_COUNT{CELL_WALL}};
      player_x_q   <= START_X4;
      player_y_q   <= START_Y4;
      move_count_q <= '0;
      bump_q       <= 1'b0;
      active_q     <= 1'b0;
      won_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      snapshot_q   <= snapshot_d;
      player_x_q   <= player_x_d;
      player_y_q   <= player_y_d;
      move_count_q <= move_count_d;
      bump_q       <= bump_d;
      active_q     <= active_d;
      won_q        <= won_d;
    end
  end

  assign player_x   = player_x_q;
  assign player_y   = player_y_q;
  assign move_count = move_count_q;
  assign bump       = bump_q;
  assign active     = active_q;
  assign won        = won_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed bench for maze_player_ctrl: expected outputs are queued as each
// step is driven and compared once the clock edge has produced the result.
module tb_maze_player_ctrl;

  localparam int RC = 4;

  localparam logic [3:0] B_NONE  = 4'b0000;
  localparam logic [3:0] B_UP    = 4'b1000;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0001;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [9:0] cnt;
    logic       bump;
    logic       active;
    logic       won;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         maze_finish;
  logic [255:0] maze_data;
  logic         btn_up, btn_down, btn_left, btn_right;
  logic [3:0]   player_x, player_y;
  logic [9:0]   move_count;
  logic         bump, active, won;

  obs_t  exp_q[$];
  string tag_q[$];
  obs_t  last_exp;
  int    checks = 0;
  int    passes = 0;

  logic [255:0] maze_a, maze_b, maze_c, maze_d;

  always #5 clk = ~clk;

  maze_player_ctrl #(
    .START_X      (1),
    .START_Y      (1),
    .GOAL_X       (14),
    .GOAL_Y       (14),
    .REPEAT_CYCLES(RC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .maze_finish(maze_finish),
    .maze_data  (maze_data),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .player_x   (player_x),
    .player_y   (player_y),
    .move_count (move_count),
    .bump       (bump),
    .active     (active),
    .won        (won)
  );

  function automatic obs_t mk(input int x, input int y, input int cnt,
                              input logic b, input logic a, input logic w);
    obs_t o;
    o.x = 4'(x); o.y = 4'(y); o.cnt = 10'(cnt);
    o.bump = b; o.active = a; o.won = w;
    return o;
  endfunction

  function automatic logic [255:0] add_cell(input logic [255:0] m, input int x, input int y);
    logic [255:0] r;
    r = m;
    r[x + 16 * y] = 1'b1;
    return r;
  endfunction

  task automatic applyStimulus(input logic [3:0] btn, input string tag, input obs_t expected);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = btn;
    exp_q.push_back(expected);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    obs_t  e;
    obs_t  o;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {player_x, player_y, move_count, bump, active, won};
    assert (o === e) passes++;
    else $error("[TB] FAIL %s: observed x=%0d y=%0d cnt=%0d bump=%b active=%b won=%b, expected x=%0d y=%0d cnt=%0d bump=%b active=%b won=%b",
                t, o.x, o.y, o.cnt, o.bump, o.active, o.won, e.x, e.y, e.cnt, e.bump, e.active, e.won);
    last_exp = e;
  endtask

  task automatic step(input logic [3:0] btn, input string tag, input obs_t expected);
    applyStimulus(btn, tag, expected);
    checkOutput();
  endtask

  task automatic restart_maze(input logic [255:0] map, input logic [3:0] drop_btn, input string tag);
    maze_finish = 1'b0;
    step(drop_btn, {tag, " drop"}, mk(1, 1, int'(last_exp.cnt), 1'b0, 1'b0, 1'b0));
    maze_data   = map;
    maze_finish = 1'b1;
    step(B_NONE, {tag, " load"}, mk(1, 1, 0, 1'b0, 1'b1, 1'b0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    maze_a = '0;
    maze_a = add_cell(maze_a, 1, 1);
    maze_a = add_cell(maze_a, 2, 1);
    maze_b = '0;
    for (int x = 1; x <= 6; x++) maze_b = add_cell(maze_b, x, 1);
    maze_c = '0;
    for (int x = 0; x <= 15; x++) maze_c = add_cell(maze_c, x, 1);
    maze_c = add_cell(maze_c, 15, 0);
    maze_c = add_cell(maze_c, 15, 15);
    maze_d = '0;
    for (int x = 1; x <= 14; x++) maze_d = add_cell(maze_d, x, 1);
    for (int y = 1; y <= 14; y++) maze_d = add_cell(maze_d, 14, y);

    reset = 1'b1;
    maze_finish = 1'b0;
    maze_data = maze_a;
    {btn_up, btn_down, btn_left, btn_right} = B_NONE;
    last_exp = mk(1, 1, 0, 1'b0, 1'b0, 1'b0);

    step(B_NONE, "reset", mk(1, 1, 0, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;
    for (int i = 0; i < 20; i++)
      step((i % 2 == 0) ? B_RIGHT : B_DOWN, $sformatf("wait ignore %0d", i), mk(1, 1, 0, 1'b0, 1'b0, 1'b0));

    // Maze A: one legal step right, then a wall below.
    restart_maze(maze_a, B_RIGHT, "A");
    step(B_RIGHT, "A right", mk(2, 1, 1, 1'b0, 1'b1, 1'b0));
    step(B_NONE,  "A idle",  mk(2, 1, 1, 1'b0, 1'b1, 1'b0));
    step(B_DOWN,  "A down wall", mk(2, 1, 1, 1'b1, 1'b1, 1'b0));
    step(B_NONE,  "A bump clear", mk(2, 1, 1, 1'b0, 1'b1, 1'b0));

    // Maze B: auto-repeat while holding right; drop wins over a legal left.
    restart_maze(maze_b, B_LEFT, "B");
    for (int i = 0; i < 13; i++)
      step(B_RIGHT, $sformatf("B hold %0d", i), mk(2 + i / 4, 1, 1 + i / 4, 1'b0, 1'b1, 1'b0));
    step(B_NONE, "B release", mk(5, 1, 4, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++)
      step(B_UP | B_RIGHT, $sformatf("B two buttons %0d", i), mk(5, 1, 4, 1'b0, 1'b1, 1'b0));

    // Maze C: walk to the right edge and the top edge; wrap cells are path.
    restart_maze(maze_c, B_NONE, "C");
    for (int k = 1; k <= 14; k++) begin
      step(B_RIGHT, $sformatf("C right %0d", k), mk(1 + k, 1, k, 1'b0, 1'b1, 1'b0));
      step(B_NONE,  $sformatf("C rel %0d", k),   mk(1 + k, 1, k, 1'b0, 1'b1, 1'b0));
    end
    step(B_RIGHT, "C right edge", mk(15, 1, 14, 1'b1, 1'b1, 1'b0));
    step(B_NONE,  "C rel edge",   mk(15, 1, 14, 1'b0, 1'b1, 1'b0));
    step(B_UP,    "C up",         mk(15, 0, 15, 1'b0, 1'b1, 1'b0));
    step(B_NONE,  "C rel up",     mk(15, 0, 15, 1'b0, 1'b1, 1'b0));
    step(B_UP,    "C top edge",   mk(15, 0, 15, 1'b1, 1'b1, 1'b0));
    step(B_NONE,  "C rel top",    mk(15, 0, 15, 1'b0, 1'b1, 1'b0));

    reset = 1'b1;
    step(B_RIGHT, "mid reset", mk(1, 1, 0, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;

    // Maze D: live bitmap cleared after load; the snapshot still guides moves.
    restart_maze(maze_d, B_NONE, "D");
    maze_data = '0;
    for (int k = 1; k <= 13; k++) begin
      step(B_RIGHT, $sformatf("D right %0d", k), mk(1 + k, 1, k, 1'b0, 1'b1, 1'b0));
      step(B_NONE,  $sformatf("D rel r%0d", k),  mk(1 + k, 1, k, 1'b0, 1'b1, 1'b0));
    end
    for (int k = 1; k <= 13; k++) begin
      step(B_DOWN, $sformatf("D down %0d", k), mk(14, 1 + k, 13 + k, 1'b0, k != 13, k == 13));
      step(B_NONE, $sformatf("D rel d%0d", k), mk(14, 1 + k, 13 + k, 1'b0, k != 13, k == 13));
    end
    step(B_UP,   "won frozen up",   mk(14, 14, 26, 1'b0, 1'b0, 1'b1));
    step(B_NONE, "won frozen rel",  mk(14, 14, 26, 1'b0, 1'b0, 1'b1));
    step(B_LEFT, "won frozen left", mk(14, 14, 26, 1'b0, 1'b0, 1'b1));
    restart_maze(maze_d, B_NONE, "D again");
    step(B_RIGHT, "D again right", mk(2, 1, 1, 1'b0, 1'b1, 1'b0));

    // Saturation: alternate right/left so every cycle is a new direction.
    restart_maze(maze_a, B_NONE, "sat");
    for (int i = 1; i <= 1030; i++)
      step((i % 2 == 1) ? B_RIGHT : B_LEFT, $sformatf("sat %0d", i),
           mk((i % 2 == 1) ? 2 : 1, 1, (i < 1023) ? i : 1023, 1'b0, 1'b1, 1'b0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
